// File: rtl/swervolf_uart_pkg.sv
// Shared definitions for the SweRVolf console UART blocks: receiver state
// encoding and the clock divider calculation.
package swervolf_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 32'd2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output and a
// drop-on-full push that reports the lost word.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             wr_en_s;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign pop_s    = pop & ~empty_s;
    assign wr_en_s  = push & (~full_s | pop_s);
    assign overflow = push & ~wr_en_s;
    assign valid    = ~empty_s;
    assign fill     = wr_ptr_r - rd_ptr_r;
    assign data     = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver for the SweRVolf console line, buffering received bytes
// in a FWFT FIFO exposed as a valid/ready stream.
module uart_rx_fifo
    import swervolf_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill,
    output logic                          o_frame_err,
    output logic                          o_overflow
);
    localparam int unsigned DIV   = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int          CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 32'd1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 32'd2 - 32'd1);

    rx_state_e        state_r;
    logic             sync1_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_r;
    logic [7:0]       shift_r;
    logic             push_r;
    logic             frame_err_r;
    logic             fall_s;
    logic             expire_s;

    assign fall_s   = rx_prev_r & ~rx_sync_r;
    assign expire_s = (cnt_r == '0);

    // Two-flop synchroniser plus one history flop for edge detection; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= i_rx;
            rx_sync_r <= sync1_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver FSM: samples mid-bit and stops at the middle of the stop bit
    // so the next start edge can follow immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            bit_r       <= 3'd0;
            shift_r     <= 8'd0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r <= ST_START;
                        cnt_r   <= HALF_M1;
                    end
                end
                ST_START: begin
                    if (!expire_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (!rx_sync_r) begin
                        state_r <= ST_DATA;
                        bit_r   <= 3'd0;
                        cnt_r   <= FULL_M1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!expire_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        cnt_r   <= FULL_M1;
                        bit_r   <= bit_r + 3'd1;
                        if (bit_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!expire_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (rx_sync_r) begin
                        push_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx_sync_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_frame_err = frame_err_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_r),
        .push_data (shift_r),
        .pop       (i_ready),
        .data      (o_data),
        .valid     (o_valid),
        .fill      (o_fill),
        .overflow  (o_overflow)
    );

endmodule
